// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised SPI master, SCLK from a clk-enable divider, no derived clock
// Optional feature macro: SPI_BURST_EN (adds cmd_last_i, holds CS low between words of a burst)
module spi_master_param #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_CS  = 1,
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [DATA_W-1:0] cmd_data_i,
    input  logic [CS_W-1:0]   cmd_cs_i,
    input  logic              cmd_cpol_i,
    input  logic              cmd_cpha_i,
`ifdef SPI_BURST_EN
    input  logic              cmd_last_i,
`endif
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              busy_o,
    output logic              spi_sclk_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i,
    output logic [NUM_CS-1:0] spi_cs_n_o
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int HALF_W = $clog2(2 * DATA_W);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_RESP,
        S_BURST_WAIT
    } state_t;

    state_t              state_q;
    logic [DIV_W-1:0]    div_q;
    logic [HALF_W-1:0]   half_q;
    logic [DATA_W-1:0]   tx_q;
    logic [DATA_W-1:0]   rx_q;
    logic                cpol_q;
    logic                cpha_q;
    logic                last_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                busy_q;
    logic                sclk_q;
    logic                mosi_q;
    logic [NUM_CS-1:0]   cs_n_q;

    logic                half_end_d;
    logic                accept_d;
    logic                cmd_last_d;
    logic [NUM_CS-1:0]   cs_sel_d;

    assign half_end_d = (div_q == DIV_LAST);
    assign accept_d   = cmd_valid_i && cmd_ready_q;

`ifdef SPI_BURST_EN
    assign cmd_last_d = cmd_last_i;
`else
    assign cmd_last_d = 1'b1;
`endif

    // An out-of-range index matches no bit, so the word runs with every CS released.
    always_comb begin
        cs_sel_d = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(cmd_cs_i) == i) cs_sel_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            half_q      <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            last_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= '1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        state_q     <= S_SETUP;
                        div_q       <= '0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        tx_q        <= cmd_data_i;
                        cpol_q      <= cmd_cpol_i;
                        cpha_q      <= cmd_cpha_i;
                        last_q      <= cmd_last_d;
                        sclk_q      <= cmd_cpol_i;
                        cs_n_q      <= cs_sel_d;
                        mosi_q      <= cmd_cpha_i ? 1'b0 : cmd_data_i[DATA_W-1];
                    end
                end
                S_SETUP: begin
                    div_q <= div_q + 1'b1;
                    if (half_end_d) begin
                        state_q <= S_SHIFT;
                        div_q   <= '0;
                        half_q  <= '0;
                    end
                end
                S_SHIFT: begin
                    // SCLK toggles at the end of every half; even halves end on a leading edge.
                    div_q <= div_q + 1'b1;
                    if (half_end_d) begin
                        div_q  <= '0;
                        sclk_q <= ~sclk_q;
                        if (half_q[0] == cpha_q) begin
                            rx_q <= {rx_q[DATA_W-2:0], spi_miso_i};
                        end else begin
                            mosi_q <= cpha_q ? tx_q[DATA_W-1] : tx_q[DATA_W-2];
                            tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
                        end
                        if (half_q == HALF_LAST) begin
                            state_q <= S_HOLD;
                            mosi_q  <= 1'b0;
                        end else begin
                            half_q <= half_q + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    div_q <= div_q + 1'b1;
                    if (half_end_d) begin
                        div_q       <= '0;
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= rx_q;
                        if (last_q) cs_n_q <= '1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        if (last_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_BURST_WAIT;
                        end
                    end
                end
                S_BURST_WAIT: begin
                    // Continuation words keep the chip select and mode latched by the first word.
                    if (accept_d) begin
                        state_q     <= S_SHIFT;
                        div_q       <= '0;
                        half_q      <= '0;
                        cmd_ready_q <= 1'b0;
                        tx_q        <= cmd_data_i;
                        last_q      <= cmd_last_d;
                        mosi_q      <= cpha_q ? 1'b0 : cmd_data_i[DATA_W-1];
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = busy_q;
    assign spi_sclk_o  = sclk_q;
    assign spi_mosi_o  = mosi_q;
    assign spi_cs_n_o  = cs_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - scoreboard bench for spi_master_param (pattern and loopback MISO slave)
`timescale 1ns/1ps
module tb_spi_master_param;

    localparam int DW        = 8;
    localparam int CD        = 4;
    localparam int LAT       = (2 * DW + 2) * CD + 1;
    localparam int LAT_BURST = (2 * DW + 1) * CD + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0;
    logic [DW-1:0] cmd_data  = '0;
    logic [1:0]    cmd_cs    = '0;
    logic          cmd_cpol  = 1'b0;
    logic          cmd_cpha  = 1'b0;
`ifdef SPI_BURST_EN
    logic          cmd_last  = 1'b1;
`endif
    logic          rsp_ready = 1'b0;

    logic          cmd_ready, rsp_valid, busy, sclk, mosi, miso;
    logic [DW-1:0] rsp_data;
    logic [3:0]    cs_n;
    logic          cmd_ready3, rsp_valid3, busy3, sclk3, mosi3;
    logic [DW-1:0] rsp_data3;
    logic [2:0]    cs_n3;

    spi_master_param #(.DATA_W(DW), .CLK_DIV(CD), .NUM_CS(4)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_data_i(cmd_data),
        .cmd_cs_i(cmd_cs), .cmd_cpol_i(cmd_cpol), .cmd_cpha_i(cmd_cpha),
`ifdef SPI_BURST_EN
        .cmd_last_i(cmd_last),
`endif
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .busy_o(busy), .spi_sclk_o(sclk), .spi_mosi_o(mosi), .spi_miso_i(miso),
        .spi_cs_n_o(cs_n)
    );

    spi_master_param #(.DATA_W(DW), .CLK_DIV(CD), .NUM_CS(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready3), .cmd_data_i(cmd_data),
        .cmd_cs_i(cmd_cs), .cmd_cpol_i(cmd_cpol), .cmd_cpha_i(cmd_cpha),
`ifdef SPI_BURST_EN
        .cmd_last_i(cmd_last),
`endif
        .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data3),
        .busy_o(busy3), .spi_sclk_o(sclk3), .spi_mosi_o(mosi3), .spi_miso_i(mosi3),
        .spi_cs_n_o(cs_n3)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int hs_cyc      = 0;
    logic [DW-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave-side monitor: counts SCLK edges and captures MOSI as a real slave would.
    logic          cur_cpha = 1'b0;
    logic          in_burst = 1'b0;
    logic          pat_en   = 1'b0;
    logic [DW-1:0] pat_word = 8'h3C;
    int            edge_cnt = 0, rise_cnt = 0, samp_cnt = 0, cs_rise = 0;
    logic [DW-1:0] mosi_cap = '0;
    logic          prev_sclk = 1'b0, prev_mosi = 1'b0, prev_cs0 = 1'b1, prev_busy = 1'b0;
    logic          pat_bit;

    always @(negedge clk) begin
        if (!busy) begin
            edge_cnt <= 0; rise_cnt <= 0; samp_cnt <= 0; cs_rise <= 0;
        end else if (prev_busy) begin
            if (sclk != prev_sclk) begin
                edge_cnt <= edge_cnt + 1;
                if (sclk) rise_cnt <= rise_cnt + 1;
                if (edge_cnt[0] == cur_cpha) begin
                    mosi_cap <= {mosi_cap[DW-2:0], prev_mosi};
                    samp_cnt <= samp_cnt + 1;
                end
            end
            if (cs_n[0] && !prev_cs0) cs_rise <= cs_rise + 1;
        end
        prev_sclk <= sclk; prev_mosi <= mosi; prev_cs0 <= cs_n[0]; prev_busy <= busy;
    end

    always_comb begin
        pat_bit = 1'b0;
        for (int i = 0; i < DW; i++) if (samp_cnt == DW - 1 - i) pat_bit = pat_word[i];
    end
    assign miso = pat_en ? pat_bit : mosi;

    task automatic send_cmd(input logic [DW-1:0] d, input logic [1:0] cs,
                            input logic cpol, input logic cpha, input logic last);
        bit ok;
        cmd_data = d; cmd_cs = cs; cmd_cpol = cpol; cmd_cpha = cpha;
`ifdef SPI_BURST_EN
        cmd_last = last;
`endif
        if (!in_burst) cur_cpha = cpha;
        in_burst = !last;
        cmd_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (cmd_ready) ok = 1; else @(negedge clk);
        end
        chk("cmd_accept_timeout", 32'(ok), 1);
        hs_cyc = cyc;
        exp_q.push_back(pat_en ? pat_word : d);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input int lat);
        bit ok;
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (rsp_valid) ok = 1; else @(negedge clk);
        end
        chk("rsp_timeout", 32'(ok), 1);
        chk("rsp_latency", cyc - hs_cyc, lat);
    endtask

    task automatic take_rsp();
        logic [DW-1:0] snap;
        snap = rsp_data;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_clear", 32'(rsp_valid), 0);
        if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
        else chk("rsp_data", 32'(snap), 32'(exp_q.pop_front()));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] vec [2];
        logic [DW-1:0] snap;
        bit flag_rdy, flag_chg, ok;
        vec[0] = 8'h81; vec[1] = 8'h5A;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sclk_mosi", {30'd0, sclk, mosi}, 0);
        chk("rst_cs_n", 32'(cs_n), 32'hF);
        rst = 1'b0;
        @(negedge clk);

        // Mode 0 with a patterned slave
        pat_en = 1'b1;
        send_cmd(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("m0_setup_cs", 32'(cs_n), 32'hE);
        chk("m0_setup_mosi", 32'(mosi), 1);
        wait_valid(LAT);
        chk("m0_rises", rise_cnt, 8);
        chk("m0_mosi_bits", 32'(mosi_cap), 32'hA5);
        chk("m0_cs_release", 32'(cs_n), 32'hF);
        take_rsp();
        pat_en = 1'b0;

        // Modes 1..3 in loopback
        for (int m = 1; m < 4; m++) begin
            for (int k = 0; k < 2; k++) begin
                send_cmd(vec[k], 2'd1, m[1], m[0], 1'b1);
                chk("mode_setup_sclk", 32'(sclk), 32'(m[1]));
                chk("mode_setup_cs", 32'(cs_n), 32'hD);
                wait_valid(LAT);
                chk("mode_edges", edge_cnt, 2 * DW);
                chk("mode_mosi_bits", 32'(mosi_cap), 32'(vec[k]));
                take_rsp();
                @(negedge clk);
                chk("mode_idle_sclk", 32'(sclk), 32'(m[1]));
            end
        end

        // Stalled response blocks the next command
        send_cmd(8'h4B, 2'd0, 1'b0, 1'b0, 1'b1);
        wait_valid(LAT);
        snap = rsp_data;
        cmd_data = 8'hD2; cmd_cs = 2'd0; cmd_cpol = 1'b0; cmd_cpha = 1'b0;
        cmd_valid = 1'b1;
        flag_rdy = 0; flag_chg = 0;
        repeat (50) begin
            @(negedge clk);
            if (cmd_ready) flag_rdy = 1;
            if (rsp_data !== snap || !rsp_valid) flag_chg = 1;
        end
        chk("stall_cmd_ready", 32'(flag_rdy), 0);
        chk("stall_rsp_stable", 32'(flag_chg), 0);
        take_rsp();
        send_cmd(8'hD2, 2'd0, 1'b0, 1'b0, 1'b1);
        wait_valid(LAT);
        take_rsp();

        // Chip-select decode, including an index beyond NUM_CS on the 3-select instance
        send_cmd(8'hC3, 2'd2, 1'b0, 1'b0, 1'b1);
        chk("cs2_main", 32'(cs_n), 32'hB);
        chk("cs2_dut3", 32'(cs_n3), 32'h3);
        chk("dut3_setup", {29'd0, busy3, cmd_ready3, sclk3}, 32'h4);
        wait_valid(LAT);
        chk("cs2_dut3_rsp", {23'd0, rsp_valid3, rsp_data3}, 32'h1C3);
        take_rsp();
        send_cmd(8'h96, 2'd3, 1'b0, 1'b0, 1'b1);
        chk("cs3_main", 32'(cs_n), 32'h7);
        chk("cs_oob_dut3", 32'(cs_n3), 32'h7);
        wait_valid(LAT);
        chk("cs_oob_dut3_rsp", {23'd0, rsp_valid3, rsp_data3}, 32'h196);
        take_rsp();

        // Reset in the middle of a mode-3 word
        send_cmd(8'hE7, 2'd0, 1'b1, 1'b1, 1'b1);
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (samp_cnt == 4) ok = 1; else @(negedge clk);
        end
        chk("midword_reach", 32'(ok), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_cs_n", 32'(cs_n), 32'hF);
        chk("abort_sclk", 32'(sclk), 0);
        chk("abort_rsp_busy", {30'd0, rsp_valid, busy}, 0);
        chk("abort_ready", 32'(cmd_ready), 1);
        rst = 1'b0;
        exp_q.delete();
        in_burst = 1'b0;
        @(negedge clk);
        send_cmd(8'h5C, 2'd0, 1'b0, 1'b0, 1'b1);
        wait_valid(LAT);
        chk("post_reset_bits", 32'(mosi_cap), 32'h5C);
        take_rsp();

`ifdef SPI_BURST_EN
        // Three-word burst under one chip select
        send_cmd(8'h11, 2'd0, 1'b0, 1'b0, 1'b0);
        wait_valid(LAT);
        take_rsp();
        chk("burst_wait_cs", 32'(cs_n), 32'hE);
        chk("burst_wait_ready", {30'd0, cmd_ready, busy}, 32'h3);
        send_cmd(8'h22, 2'd1, 1'b1, 1'b1, 1'b0);
        chk("burst_cs_kept", 32'(cs_n), 32'hE);
        wait_valid(LAT_BURST);
        take_rsp();
        send_cmd(8'h33, 2'd2, 1'b0, 1'b0, 1'b1);
        wait_valid(LAT_BURST);
        chk("burst_rises", rise_cnt, 3 * DW);
        chk("burst_cs_rises", cs_rise, 1);
        chk("burst_cs_release", 32'(cs_n), 32'hF);
        take_rsp();
`endif

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
